// File: rtl/txn_initiator.sv
// Self-test initiator: issues NUM_TXN select-op requests, checks each response, reports err_count/pass.
// Latency: start->ISSUE 1 cycle; minimum 3 cycles per transaction (ISSUE, WAIT_RESP, CHECK).
// Backpressure: request outputs held while req_ready=0; TXN_INIT_STOP_ON_ERR_EN ends the run at the first mismatch.
module txn_initiator #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned NUM_TXN = 16,
    parameter int unsigned SEED    = 8'h10,
    parameter int unsigned STEP    = 3,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             req_valid,
    input  logic             req_ready,
    output logic [WIDTH-1:0] req_data,
    output logic [4:0]       req_sel,
    input  logic             resp_valid,
    input  logic [WIDTH-1:0] resp_data,
    output logic [7:0]       err_count,
    output logic             timeout_err
);

    localparam logic [WIDTH-1:0] SEED_W   = WIDTH'(SEED);
    localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);
    localparam logic [7:0]       IDX_LAST = 8'(NUM_TXN - 1);
    localparam logic [7:0]       WAIT_MAX = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_RESP,
        S_CHECK,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [7:0]       idx;
    logic [7:0]       idx_inc;
    logic [7:0]       wcnt;
    logic [WIDTH-1:0] resp_q;
    logic [WIDTH-1:0] expected;
    logic             mismatch;
    logic             start_run;
    logic             xfer;
    logic             timeout_hit;
    logic             next_txn;

    // Expected value is derived from the request still held on req_data/req_sel.
    always_comb begin
        expected = '0;
        case (req_sel)
            5'd0:    expected = req_data + WIDTH'(1);
            5'd1:    expected = ~req_data;
            default: expected = '0;
        endcase
    end

    assign mismatch = (resp_q != expected);
    assign idx_inc  = idx + 8'd1;

    always_comb begin
        state_nx    = state;
        start_run   = 1'b0;
        xfer        = 1'b0;
        timeout_hit = 1'b0;
        next_txn    = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    start_run = 1'b1;
                    state_nx  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (req_valid && req_ready) begin
                    xfer     = 1'b1;
                    state_nx = S_WAIT_RESP;
                end
            end
            S_WAIT_RESP: begin
                if (resp_valid) begin
                    state_nx = S_CHECK;
                end else if (wcnt == WAIT_MAX) begin
                    timeout_hit = 1'b1;
                    state_nx    = S_DONE;
                end
            end
            S_CHECK: begin
`ifdef TXN_INIT_STOP_ON_ERR_EN
                if (mismatch || idx == IDX_LAST) begin
                    state_nx = S_DONE;
                end else begin
                    next_txn = 1'b1;
                    state_nx = S_ISSUE;
                end
`else
                if (idx == IDX_LAST) begin
                    state_nx = S_DONE;
                end else begin
                    next_txn = 1'b1;
                    state_nx = S_ISSUE;
                end
`endif
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            idx         <= '0;
            wcnt        <= '0;
            resp_q      <= '0;
            req_valid   <= 1'b0;
            req_data    <= '0;
            req_sel     <= '0;
            err_count   <= '0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_nx;
            if (start_run) begin
                idx         <= '0;
                err_count   <= '0;
                timeout_err <= 1'b0;
                req_valid   <= 1'b1;
                req_data    <= SEED_W;
                req_sel     <= '0;
            end
            if (xfer) begin
                req_valid <= 1'b0;
                wcnt      <= '0;
            end
            // The transfer cycle itself is ISSUE, so a same-cycle resp_valid never lands here.
            if (state == S_WAIT_RESP) begin
                if (resp_valid) begin
                    resp_q <= resp_data;
                end else begin
                    wcnt <= wcnt + 8'd1;
                end
            end
            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end
            if (state == S_CHECK) begin
                if (mismatch && err_count != 8'hFF) begin
                    err_count <= err_count + 8'd1;
                end
                if (next_txn) begin
                    idx       <= idx_inc;
                    req_valid <= 1'b1;
                    req_data  <= req_data + STEP_W;
                    req_sel   <= {3'b000, idx_inc[1:0]};
                end
            end
        end
    end

    assign busy = (state == S_ISSUE) || (state == S_WAIT_RESP) || (state == S_CHECK);
    assign done = (state == S_DONE);
    assign pass = done && (err_count == 8'd0) && !timeout_err;

endmodule

// File: tb/tb_txn_initiator.sv
// Bench for txn_initiator: table of responder behaviours plus randomized runs against a reference model.
module tb_txn_initiator;

    localparam int NTX  = 16;
    localparam int SEED = 16;
    localparam int STEP = 3;
    localparam int TMO  = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       busy, done, pass;
    logic       req_valid, req_ready;
    logic [7:0] req_data;
    logic [4:0] req_sel;
    logic       resp_valid;
    logic [7:0] resp_data;
    logic [7:0] err_count;
    logic       timeout_err;

    txn_initiator dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_sel(req_sel),
        .resp_valid(resp_valid), .resp_data(resp_data), .err_count(err_count),
        .timeout_err(timeout_err)
    );

    initial forever #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_data(input int i);
        int v;
        v = (SEED + i * STEP) % 256;
        return 8'(v);
    endfunction

    function automatic logic [7:0] m_resp(input logic [7:0] d, input logic [4:0] s);
        if (s == 5'd0) return d + 8'd1;
        if (s == 5'd1) return ~d;
        return 8'h00;
    endfunction

    // Responder configuration and transfer log.
    logic [15:0] cfg_mask;
    int          cfg_drop;
    bit          cfg_spur;
    bit          cfg_rand;
    int          cur_rd;
    int          cur_pd;
    logic [7:0]  xd_q[$];
    logic [4:0]  xs_q[$];
    int          last_xfer_cyc;
    int          stall_viol;

    logic       xfer, stall_prev;
    logic [7:0] xd, hold_d, pend_val, good;
    logic [4:0] xs, hold_s;
    int         pend, rwait, k;

    initial begin
        req_ready = 1'b0; resp_valid = 1'b0; resp_data = 8'h00;
        pend = 0; rwait = 0; stall_prev = 1'b0;
        hold_d = 8'h00; hold_s = 5'd0; pend_val = 8'h00;
        forever begin
            @(negedge clk);
            xfer = rst && req_valid && req_ready;
            xd = req_data;
            xs = req_sel;
            if (stall_prev && rst && !(req_valid && req_data == hold_d && req_sel == hold_s))
                stall_viol++;
            stall_prev = rst && req_valid && !req_ready;
            hold_d = req_data;
            hold_s = req_sel;
            @(posedge clk);
            #1;
            if (!rst) begin
                pend = 0; rwait = 0; resp_valid = 1'b0; req_ready = 1'b0;
            end else begin
                if (xfer) begin
                    xd_q.push_back(xd);
                    xs_q.push_back(xs);
                    last_xfer_cyc = cyc;
                    k = xd_q.size() - 1;
                    good = m_resp(xd, xs);
                    if (cfg_rand) begin
                        cur_rd = $urandom_range(0, 3);
                        cur_pd = $urandom_range(1, 6);
                    end
                    if (k == cfg_drop) begin
                        pend = 0;
                    end else begin
                        pend = cur_pd;
                        pend_val = (k < 16 && cfg_mask[k]) ? ((good == 8'hFF) ? 8'h00 : 8'hFF) : good;
                    end
                    rwait = 0;
                end
                resp_valid = 1'b0;
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        resp_valid = 1'b1;
                        resp_data  = pend_val;
                    end
                end else if (cfg_spur && req_valid) begin
                    resp_valid = 1'b1;
                    resp_data  = 8'hA5;
                end
                if (req_valid) begin
                    req_ready = (rwait >= cur_rd);
                    rwait++;
                end else begin
                    req_ready = (cur_rd == 0);
                    rwait = 0;
                end
            end
        end
    end

    typedef struct {
        int          rd;
        int          pd;
        logic [15:0] mask;
        int          drop;
        bit          spur;
        bit          bstart;
        int          e_err;
        bit          e_to;
        bit          e_pass;
        int          e_ntx;
        int          e_cyc;
    } row_t;

    row_t rows[8];

    task automatic run_row(input row_t r, input bit rnd);
        int cnt;
        int to_cyc;
        cfg_mask = r.mask; cfg_drop = r.drop; cfg_spur = r.spur; cfg_rand = rnd;
        cur_rd = r.rd; cur_pd = r.pd;
        xd_q.delete(); xs_q.delete(); stall_viol = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cnt = 0;
        to_cyc = -1;
        while (cnt < 3000) begin
            @(posedge clk);
            cnt++;
            #1 start = r.bstart && busy && (cnt % 5 == 2);
            @(negedge clk);
            if (cnt == 1) chk("busy_run", busy, 1);
            if (timeout_err && to_cyc < 0) to_cyc = cyc;
            if (done) break;
        end
        start = 1'b0;
        chk("done", done, 1);
        if (r.e_cyc > 0) chk("cycles", cnt, r.e_cyc);
        chk("err_count", err_count, r.e_err);
        chk("timeout_err", timeout_err, r.e_to);
        chk("pass", pass, r.e_pass);
        chk("ntx", xd_q.size(), r.e_ntx);
        for (int i = 0; i < xd_q.size() && i < r.e_ntx; i++) begin
            chk("req_data", xd_q[i], m_data(i));
            chk("req_sel", xs_q[i], i % 4);
        end
        chk("stall_hold", stall_viol, 0);
        if (r.e_to) chk("timeout_dist", to_cyc - last_xfer_cyc, TMO);
        repeat (3) @(negedge clk);
        chk("done_hold", {done, err_count, timeout_err}, {1'b1, 8'(r.e_err), r.e_to});
    endtask

    initial begin
        row_t rr;
        int   e_err;
        int   e_ntx;
        int   n;
        rst = 1'b0; start = 1'b0;
        cfg_mask = '0; cfg_drop = -1; cfg_spur = 1'b0; cfg_rand = 1'b0;
        cur_rd = 0; cur_pd = 1; stall_viol = 0; last_xfer_cyc = 0;

        //            rd pd mask      drop spur bst err to pass ntx cyc
        rows[0] = '{0, 1, 16'h0000, -1, 0, 0, 0, 0, 1, 16, 48};
        rows[1] = '{5, 1, 16'h0000, -1, 0, 0, 0, 0, 1, 16, 128};
`ifdef TXN_INIT_STOP_ON_ERR_EN
        rows[2] = '{0, 1, 16'h0002, -1, 0, 0, 1, 0, 0, 2, 6};
`else
        rows[2] = '{0, 1, 16'h0002, -1, 0, 0, 1, 0, 0, 16, 48};
`endif
        rows[3] = '{0, 1, 16'h0000, 3, 0, 0, 0, 1, 0, 4, 25};
        rows[4] = '{0, 15, 16'h0000, -1, 0, 0, 0, 0, 1, 16, 272};
        rows[5] = '{0, 16, 16'h0000, -1, 0, 0, 0, 1, 0, 1, 16};
        rows[6] = '{1, 2, 16'h0000, -1, 1, 1, 0, 0, 1, 16, 0};
`ifdef TXN_INIT_STOP_ON_ERR_EN
        rows[7] = '{2, 1, 16'h8001, -1, 0, 0, 1, 0, 0, 1, 5};
`else
        rows[7] = '{2, 1, 16'h8001, -1, 0, 0, 2, 0, 0, 16, 80};
`endif

        repeat (3) @(negedge clk);
        chk("reset_state", {busy, done, pass, req_valid, timeout_err, req_sel, req_data, err_count}, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_state", {busy, done, req_valid}, 0);

        for (int i = 0; i < 8; i++) begin
            run_row(rows[i], 1'b0);
            if (i == 0) begin
                chk("idx1_data", xd_q[1], 8'h13);
                chk("idx2_sel", xs_q[2], 5'd2);
            end
        end

        // Reset while waiting on the second response.
        cfg_mask = '0; cfg_drop = -1; cfg_spur = 1'b0; cfg_rand = 1'b0;
        cur_rd = 0; cur_pd = 4;
        xd_q.delete(); xs_q.delete();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = 0;
        while (xd_q.size() < 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rst_reach_wait", {xd_q.size() == 2, busy, req_valid}, {1'b1, 1'b1, 1'b0});
        rst = 1'b0;
        #1;
        chk("rst_async", {busy, done, pass, req_valid, timeout_err, req_sel, req_data, err_count}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        run_row(rows[0], 1'b0);
        chk("rerun_first_data", xd_q[0], 8'h10);

        // Randomized backpressure, latency and error patterns.
        for (int r = 0; r < 6; r++) begin
            rr = rows[0];
            rr.mask = (r % 3 == 0) ? 16'h0000 : 16'($urandom);
            rr.rd = $urandom_range(0, 3);
            rr.pd = $urandom_range(1, 6);
            rr.e_cyc = 0;
            e_err = 0;
            e_ntx = NTX;
            for (int i = 0; i < NTX; i++) begin
                if (rr.mask[i]) begin
                    e_err++;
`ifdef TXN_INIT_STOP_ON_ERR_EN
                    e_ntx = i + 1;
                    break;
`endif
                end
            end
            rr.e_err = e_err;
            rr.e_ntx = e_ntx;
            rr.e_pass = (e_err == 0);
            run_row(rr, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
